// File: rtl/edge_detector_fsm.sv
// Single-bit rise/fall strobe generator; MOORE selects Mealy (0) or Moore (else) variant.
// Optional two-flop input synchronizer enabled by defining EDGE_DETECTOR_SYNC_EN.
module edge_detector_fsm #(
    parameter int unsigned MOORE = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic positive_edge,
    output logic negative_edge
);

    logic d;

`ifdef EDGE_DETECTOR_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], in};
        end
    end

    assign d = sync_q[1];
`else
    assign d = in;
`endif

    generate
        if (MOORE == 0) begin : g_mealy
            logic prev;

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    prev <= 1'b0;
                end else begin
                    prev <= d;
                end
            end

            // Gated with rst so the strobes are silent while reset is held.
            assign positive_edge = rst &  d & ~prev;
            assign negative_edge = rst & ~d &  prev;
        end else begin : g_moore
            typedef enum logic [1:0] {
                S_LOW  = 2'd0,
                S_RISE = 2'd1,
                S_HIGH = 2'd2,
                S_FALL = 2'd3
            } state_t;

            state_t state;
            state_t state_nxt;
            logic   pos_q;
            logic   neg_q;

            function automatic state_t next_of(input state_t s, input logic x);
                case (s)
                    S_LOW:   next_of = x ? S_RISE : S_LOW;
                    S_RISE:  next_of = x ? S_HIGH : S_FALL;
                    S_HIGH:  next_of = x ? S_HIGH : S_FALL;
                    S_FALL:  next_of = x ? S_RISE : S_LOW;
                    default: next_of = S_LOW;
                endcase
            endfunction

            assign state_nxt = next_of(state, d);

            // Outputs are registered alongside the state so they equal its decode.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state <= S_LOW;
                    pos_q <= 1'b0;
                    neg_q <= 1'b0;
                end else begin
                    state <= state_nxt;
                    pos_q <= (state_nxt == S_RISE);
                    neg_q <= (state_nxt == S_FALL);
                end
            end

            assign positive_edge = pos_q;
            assign negative_edge = neg_q;
        end
    endgenerate

endmodule

// File: tb/tb_edge_detector_fsm.sv
// Directed bench for edge_detector_fsm: Mealy and Moore instances side by side,
// expectations queued at each drive point and popped when the outputs are sampled.
module tb_edge_detector_fsm;

    logic clk = 1'b0;
    logic rst;
    logic in;
    logic m_pos, m_neg, o_pos, o_neg;

    edge_detector_fsm #(.MOORE(0)) u_mealy (
        .clk           (clk),
        .rst           (rst),
        .in            (in),
        .positive_edge (m_pos),
        .negative_edge (m_neg)
    );

    edge_detector_fsm #(.MOORE(1)) u_moore (
        .clk           (clk),
        .rst           (rst),
        .in            (in),
        .positive_edge (o_pos),
        .negative_edge (o_neg)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cnt_m_pos = 0, cnt_m_neg = 0, cnt_o_pos = 0, cnt_o_neg = 0;

    // Reference model: value sampled at the last rising edge and the Moore strobes
    // implied by the edge of the sampled sequence.
    logic in_v    = 1'b0;
    logic rst_m   = 1'b0;
    logic s_last  = 1'b0;
    logic moore_p = 1'b0;
    logic moore_n = 1'b0;

    logic [3:0] exp_q[$];
    string      tag_q[$];

    task automatic push(input string tag);
        logic mp, mn;
        mp = rst_m &  in_v & ~s_last;
        mn = rst_m & ~in_v &  s_last;
        exp_q.push_back({mp, mn, moore_p, moore_n});
        tag_q.push_back(tag);
    endtask

    task automatic check();
        logic [3:0] exp;
        logic [3:0] obs;
        string      tag;
        exp = exp_q.pop_front();
        tag = tag_q.pop_front();
        obs = {m_pos, m_neg, o_pos, o_neg};
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed {mp,mn,op,on}=%b expected=%b", tag, obs, exp);
        end
        assert (!((m_pos === 1'b1 && m_neg === 1'b1) || (o_pos === 1'b1 && o_neg === 1'b1))) else begin
            n_err++;
            $error("FAIL %s_overlap observed=%b expected=no overlap", tag, obs);
        end
        n_chk++;
    endtask

    task automatic drive_half(input logic v, input logic r, input string tag);
        @(negedge clk);
        in    = v;
        rst   = r;
        in_v  = v;
        rst_m = r;
        push({tag, "_neg"});
        #1;
        check();
        if (m_pos === 1'b1) cnt_m_pos++;
        if (m_neg === 1'b1) cnt_m_neg++;
    endtask

    task automatic rise_half(input string tag);
        @(posedge clk);
        if (rst_m) begin
            moore_p = in_v & ~s_last;
            moore_n = ~in_v & s_last;
            s_last  = in_v;
        end
        push({tag, "_pos"});
        #1;
        check();
        if (o_pos === 1'b1) cnt_o_pos++;
        if (o_neg === 1'b1) cnt_o_neg++;
    endtask

    task automatic cycle(input logic v, input logic r, input string tag);
        drive_half(v, r, tag);
        rise_half(tag);
    endtask

    task automatic reset_assert(input string tag);
        #2;
        rst     = 1'b0;
        rst_m   = 1'b0;
        s_last  = 1'b0;
        moore_p = 1'b0;
        moore_n = 1'b0;
        push(tag);
        #1;
        check();
    endtask

    task automatic count_check(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs == exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        logic v;
        int   gap;

        rst = 1'b0;
        in  = 1'b0;
        #1;
        push("reset_init");
        check();

        // Reset hold with the input toggling.
        cycle(1'b0, 1'b0, "rst_hold0");
        cycle(1'b1, 1'b0, "rst_hold1");
        cycle(1'b0, 1'b0, "rst_hold2");
        cycle(1'b1, 1'b0, "rst_hold3");

        cycle(1'b0, 1'b1, "release_low");
        cycle(1'b0, 1'b1, "idle_low");

        // Single rise held 10 cycles, then fall held 5.
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, "rise_hold");
        for (int i = 0; i < 5; i++)  cycle(1'b0, 1'b1, "fall_hold");

        // One-cycle high pulse.
        cycle(1'b1, 1'b1, "glitch_hi");
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, "glitch_lo");

        // Random toggles.
        cnt_m_pos = 0; cnt_m_neg = 0; cnt_o_pos = 0; cnt_o_neg = 0;
        v = 1'b0;
        for (int t = 0; t < 10; t++) begin
            v   = ~v;
            gap = $urandom_range(127, 1);
            for (int g = 0; g < gap; g++) cycle(v, 1'b1, "rand");
        end
        count_check("rand_mealy_pos", cnt_m_pos, 5);
        count_check("rand_mealy_neg", cnt_m_neg, 5);
        count_check("rand_moore_pos", cnt_o_pos, 5);
        count_check("rand_moore_neg", cnt_o_neg, 5);

        // Reset during a Mealy pulse, released with in high.
        drive_half(1'b1, 1'b1, "mid_mealy");
        reset_assert("mid_mealy_rst");
        rise_half("mid_mealy_hold");
        cycle(1'b1, 1'b1, "mid_mealy_release");
        cycle(1'b1, 1'b1, "mid_mealy_after");

        // Reset during a Moore pulse.
        cycle(1'b0, 1'b1, "mid_moore_pre");
        cycle(1'b0, 1'b1, "mid_moore_pre");
        cycle(1'b1, 1'b1, "mid_moore_rise");
        reset_assert("mid_moore_rst");
        cycle(1'b1, 1'b0, "mid_moore_hold");
        cycle(1'b1, 1'b1, "mid_moore_release");
        cycle(1'b0, 1'b1, "mid_moore_fall");
        cycle(1'b0, 1'b1, "mid_moore_idle");

        n_chk++;
        assert (exp_q.size() == 0) else begin
            n_err++;
            $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
